// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe -- carry-pipelined ripple adder.
//
// The WIDTH-bit addition is split into STAGES = WIDTH/SEG segments of SEG bits.
// Stage k adds segment k of the operands plus the carry registered by stage
// k-1 (cin for stage 0). Segments that have not yet been added travel forward
// in skew registers (a_q/b_q). Segments already added travel forward in
// de-skew registers (sum_q), so that the whole sum is aligned at the last
// stage. A valid bit moves with every operation. en=0 freezes every register.
// Latency is STAGES enabled edges and throughput is one operation per enabled
// edge. WIDTH must be an integer multiple of SEG.
//
// Parameters:
//   WIDTH     operand and sum width in bits (default 8)
//   SEG       bits added per pipeline stage (default 4)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   en        pipeline advance enable (0 = hold everything)
//   valid_in  a/b/cin carry a valid operation
//   a, b      operands, WIDTH bits
//   cin       carry into bit 0
//   s         registered sum, WIDTH bits
//   cout      registered carry out of bit WIDTH-1
//   valid_out s/cout (and ovf) hold a valid result
//   ovf       registered two's-complement overflow, present only when the
//             macro ADDER_PIPE_OVF_EN is defined
// -----------------------------------------------------------------------------
module adder_pipe #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             valid_out
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SEG;

    // Per-stage registers and their next-state values.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;

    // Inputs seen by each stage: the ports for stage 0, the previous stage's
    // registers otherwise.
    logic [STAGES-1:0]            valid_in_s;
    logic [STAGES-1:0]            carry_in_s;
    logic [STAGES-1:0][WIDTH-1:0] a_in_s;
    logic [STAGES-1:0][WIDTH-1:0] b_in_s;
    logic [STAGES-1:0][WIDTH-1:0] sum_in_s;

    // Segment adder results: {carry_out, segment_sum}.
    logic [STAGES-1:0][SEG:0]     seg_s;

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // Only the not-yet-added segments of the skew registers feed the adders;
    // the remaining bits are intentionally left unloaded.
    logic unused_s;
    assign unused_s = ^{a_q, b_q, a_in_s, b_in_s};

    // Route each stage's inputs: ports into stage 0, stage k-1 into stage k.
    always_comb begin
        valid_in_s  = {STAGES{1'b0}};
        carry_in_s  = {STAGES{1'b0}};
        a_in_s      = {(STAGES*WIDTH){1'b0}};
        b_in_s      = {(STAGES*WIDTH){1'b0}};
        sum_in_s    = {(STAGES*WIDTH){1'b0}};
        valid_in_s[0] = valid_in;
        carry_in_s[0] = cin;
        a_in_s[0]     = a;
        b_in_s[0]     = b;
        for (int k = 1; k < STAGES; k++) begin
            valid_in_s[k] = valid_q[k-1];
            carry_in_s[k] = carry_q[k-1];
            a_in_s[k]     = a_q[k-1];
            b_in_s[k]     = b_q[k-1];
            sum_in_s[k]   = sum_q[k-1];
        end
    end

    // Add segment k in stage k and merge it into the travelling partial sum.
    always_comb begin
        seg_s   = {(STAGES*(SEG+1)){1'b0}};
        valid_d = valid_in_s;
        carry_d = {STAGES{1'b0}};
        a_d     = a_in_s;
        b_d     = b_in_s;
        sum_d   = sum_in_s;
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = {1'b0, a_in_s[k][k*SEG +: SEG]}
                     + {1'b0, b_in_s[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, carry_in_s[k]};
            sum_d[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
            carry_d[k]             = seg_s[k][SEG];
        end
`ifdef ADDER_PIPE_OVF_EN
        // Carry into the MSB is a^b^sum at the MSB; overflow is that XOR cout.
        ovf_d = a_in_s[STAGES-1][WIDTH-1] ^ b_in_s[STAGES-1][WIDTH-1]
              ^ seg_s[STAGES-1][SEG-1] ^ seg_s[STAGES-1][SEG];
`endif
    end

    // Pipeline registers: async clear, advance only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {STAGES{1'b0}};
            carry_q <= {STAGES{1'b0}};
            a_q     <= {(STAGES*WIDTH){1'b0}};
            b_q     <= {(STAGES*WIDTH){1'b0}};
            sum_q   <= {(STAGES*WIDTH){1'b0}};
`ifdef ADDER_PIPE_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (en) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
`ifdef ADDER_PIPE_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s         = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign valid_out = valid_q[STAGES-1];
`ifdef ADDER_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe -- scoreboard bench for adder_pipe.
// Main instance WIDTH=8/SEG=4; two 4-bit instances (SEG=2 and SEG=4) receive an
// exhaustive back-to-back stream. Expected results are pushed into queues when
// an operation is accepted; negedge monitors pop and compare, including the
// exact output cycle.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

    localparam int W  = 8;
    localparam int SG = 4;
    localparam int ST = W / SG;

    logic         clk = 1'b0;
    logic         rst;
    logic         en = 1'b0;
    logic         valid_in = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] s;
    logic         cout;
    logic         valid_out;

    logic [3:0]   x_a = '0;
    logic [3:0]   x_b = '0;
    logic         x_c = 1'b0;
    logic         x_v = 1'b0;
    logic [3:0]   s2, s4;
    logic         c2, c4, v2, v4;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf, ovf2, ovf4;
`endif

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .SEG(SG)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout), .valid_out(valid_out)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_pipe #(.WIDTH(4), .SEG(2)) dut2 (
        .clk(clk), .rst(rst), .en(1'b1), .valid_in(x_v),
        .a(x_a), .b(x_b), .cin(x_c), .s(s2), .cout(c2), .valid_out(v2)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf2)
`endif
    );

    adder_pipe #(.WIDTH(4), .SEG(4)) dut4 (
        .clk(clk), .rst(rst), .en(1'b1), .valid_in(x_v),
        .a(x_a), .b(x_b), .cin(x_c), .s(s4), .cout(c4), .valid_out(v4)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf4)
`endif
    );

    typedef struct { logic [W+1:0] r; int due; } exp8_t;
    typedef struct { logic [5:0]   r; int due; } exp4_t;

    exp8_t q[$];
    exp4_t q2[$];
    exp4_t q4[$];

    int n_vec = 0;
    int n_bad = 0;
    int edge_idx = 0;
    int cyc = 0;
    logic last_en = 1'b0;
    logic last_run = 1'b0;
    logic [W+1:0] held = '0;

    // Reference: {ovf, cout, s} from plain integer arithmetic and sign rules.
    function automatic logic [W+1:0] ref8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        logic o;
        t = int'(x) + int'(y) + int'(c);
        o = (x[W-1] == y[W-1]) && (((t >> (W-1)) & 1) != int'(x[W-1]));
        return {o, 9'(t)};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int t;
        logic o;
        t = int'(x) + int'(y) + int'(c);
        o = (x[3] == y[3]) && (((t >> 3) & 1) != int'(x[3]));
        return {o, 5'(t)};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c);
        en = e; valid_in = v; a = x; b = y; cin = c;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: record every accepted operation with its due edge.
    always @(posedge clk) begin
        last_en = (rst === 1'b0) && (en === 1'b1);
        if (last_en) begin
            if (valid_in === 1'b1)
                q.push_back('{ref8(a, b, cin), edge_idx + ST - 1});
            edge_idx++;
        end
        last_run = (rst === 1'b0);
        if (last_run) begin
            if (x_v === 1'b1) begin
                q2.push_back('{ref4(x_a, x_b, x_c), cyc + 1});
                q4.push_back('{ref4(x_a, x_b, x_c), cyc});
            end
            cyc++;
        end
    end

    // Main monitor: result exactly when due, idle otherwise, frozen on stalls.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            held = '0;
        end else if (rst === 1'b0 && last_en) begin
            if (q.size() > 0 && q[0].due == edge_idx - 1) begin
                check("valid_out", 32'(valid_out), 32'd1);
                check("sum8", 32'({cout, s}), 32'(q[0].r[W:0]));
`ifdef ADDER_PIPE_OVF_EN
                check("ovf8", 32'(ovf), 32'(q[0].r[W+1]));
`endif
                void'(q.pop_front());
            end else begin
                check("idle8", 32'(valid_out), 32'd0);
            end
            held = {1'b0, valid_out, cout, s};
        end else if (rst === 1'b0) begin
            check("stall_hold", 32'({1'b0, valid_out, cout, s}), 32'(held));
        end
    end

    // Monitors for the exhaustive 4-bit instances (always enabled).
    always @(negedge clk) begin
        if (rst === 1'b0 && last_run) begin
            if (q2.size() > 0 && q2[0].due == cyc - 1) begin
                check("v_w4s2", 32'(v2), 32'd1);
                check("sum_w4s2", 32'({c2, s2}), 32'(q2[0].r[4:0]));
`ifdef ADDER_PIPE_OVF_EN
                check("ovf_w4s2", 32'(ovf2), 32'(q2[0].r[5]));
`endif
                void'(q2.pop_front());
            end else begin
                check("idle_w4s2", 32'(v2), 32'd0);
            end
            if (q4.size() > 0 && q4[0].due == cyc - 1) begin
                check("v_w4s4", 32'(v4), 32'd1);
                check("sum_w4s4", 32'({c4, s4}), 32'(q4[0].r[4:0]));
`ifdef ADDER_PIPE_OVF_EN
                check("ovf_w4s4", 32'(ovf4), 32'(q4[0].r[5]));
`endif
                void'(q4.pop_front());
            end else begin
                check("idle_w4s4", 32'(v4), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        #1 rst = 1'b0;

        // Single wrap-around operation, then bubbles.
        step(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Back-to-back operations.
        step(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'hF0, 8'h10, 1'b1);
        step(1'b1, 1'b1, 8'h55, 8'hAA, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Stall: junk with valid_in=1 during en=0 must be ignored.
        step(1'b1, 1'b1, 8'h3C, 8'h0C, 1'b0);
        repeat (3) step(1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Signed overflow corners.
        step(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Randomized traffic with random stalls and bubbles.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset mid-flight: results must vanish at once and never reappear.
        step(1'b1, 1'b1, 8'h21, 8'h43, 1'b1);
        step(1'b1, 1'b1, 8'hA5, 8'h5A, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_valid", 32'(valid_out), 32'd0);
        q.delete();
        q2.delete();
        q4.delete();
        en = 1'b1; valid_in = 1'b1; a = 8'h99; b = 8'h99;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // First operation after reset accepted on the next enabled edge.
        step(1'b1, 1'b1, 8'h80, 8'h7F, 1'b1);
        repeat (4) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Exhaustive 4-bit stream, back-to-back.
        en = 1'b1; valid_in = 1'b0;
        for (int i = 0; i < 512; i++) begin
            x_a = 4'(i);
            x_b = 4'(i >> 4);
            x_c = 1'(i >> 8);
            x_v = 1'b1;
            @(posedge clk);
            #1;
        end
        x_v = 1'b0;
        repeat (4) @(posedge clk);
        #6;

        check("drain8", 32'(q.size()), 32'd0);
        check("drain_w4s2", 32'(q2.size()), 32'd0);
        check("drain_w4s4", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
